trap_seq_ctrl: RTL and testbench

- Trap/interrupt sequencer for the machine-mode CSR file. On ecall, ebreak, an enabled interrupt or mret, it stalls the pipeline and drives the CSR file's secondary write port one CSR per cycle (mepc, mcause, mstatus).
- It then issues a PC redirect to mtvec, or to mepc on return.
- It sits between the execute stage, the interrupt source and the CSR register file; its write port has lower priority than execute-stage CSR writes.

---
 rtl/trap_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_trap_seq_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/trap_seq_ctrl.sv
// ============================================================================
// Module   : trap_seq_ctrl
// Brief    : Machine-mode trap/interrupt entry and mret sequencer that drives
//            the CSR file's secondary write port and issues the PC redirect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module trap_seq_ctrl #(
    parameter logic [31:0] IRQ_CAUSE    = 32'h8000_0007,
    parameter logic [31:0] ECALL_CAUSE  = 32'd11,
    parameter logic [31:0] EBREAK_CAUSE = 32'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_ecall_i,
    input  logic        inst_ebreak_i,
    input  logic        inst_mret_i,
    input  logic [31:0] inst_addr_i,
    input  logic        busy_i,
    input  logic        irq_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] mstatus_i,
    output logic        hold_o,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o
);

    localparam logic [31:0] C_ADDR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] C_ADDR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] C_ADDR_MCAUSE  = 32'h0000_0342;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W_MEPC    = 3'd1,
        S_W_MCAUSE  = 3'd2,
        S_W_MSTATUS = 3'd3,
        S_T_JUMP    = 3'd4,
        S_R_MSTATUS = 3'd5,
        S_R_JUMP    = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_cause;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_cause_nxt;
    logic        w_irq_ok;

    // Interrupts are only taken between instructions with MIE set.
    assign w_irq_ok = irq_i & mstatus_i[3] & ~busy_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= 32'd0;
            r_cause <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cause_nxt = r_cause;
        hold_o      = 1'b0;
        csr_we_o    = 1'b0;
        csr_waddr_o = 32'd0;
        csr_wdata_o = 32'd0;
        jump_flag_o = 1'b0;
        jump_addr_o = 32'd0;

        case (r_state)
            S_IDLE: begin
                // Gated by rst_n so hold_o stays low while reset is asserted.
                if (rst_n) begin
                    if (inst_ecall_i) begin
                        hold_o      = 1'b1;
                        w_pc_nxt    = inst_addr_i;
                        w_cause_nxt = ECALL_CAUSE;
                        w_state_nxt = S_W_MEPC;
                    end else if (inst_ebreak_i) begin
                        hold_o      = 1'b1;
                        w_pc_nxt    = inst_addr_i;
                        w_cause_nxt = EBREAK_CAUSE;
                        w_state_nxt = S_W_MEPC;
                    end else if (inst_mret_i) begin
                        hold_o      = 1'b1;
                        w_pc_nxt    = inst_addr_i;
                        w_state_nxt = S_R_MSTATUS;
                    end else if (w_irq_ok) begin
                        hold_o      = 1'b1;
                        w_pc_nxt    = inst_addr_i;
                        w_cause_nxt = IRQ_CAUSE;
                        w_state_nxt = S_W_MEPC;
                    end
                end
            end
            S_W_MEPC: begin
                hold_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = C_ADDR_MEPC;
                csr_wdata_o = r_pc;
                w_state_nxt = S_W_MCAUSE;
            end
            S_W_MCAUSE: begin
                hold_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = C_ADDR_MCAUSE;
                csr_wdata_o = r_cause;
                w_state_nxt = S_W_MSTATUS;
            end
            S_W_MSTATUS: begin
                // MPIE <= MIE, MIE <= 0.
                hold_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = C_ADDR_MSTATUS;
                csr_wdata_o = {mstatus_i[31:8], mstatus_i[3], mstatus_i[6:4],
                               1'b0, mstatus_i[2:0]};
                w_state_nxt = S_T_JUMP;
            end
            S_T_JUMP: begin
                hold_o      = 1'b1;
                jump_flag_o = 1'b1;
                jump_addr_o = mtvec_i;
                w_state_nxt = S_IDLE;
            end
            S_R_MSTATUS: begin
                // MIE <= MPIE, MPIE <= 1.
                hold_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = C_ADDR_MSTATUS;
                csr_wdata_o = {mstatus_i[31:8], 1'b1, mstatus_i[6:4],
                               mstatus_i[7], mstatus_i[2:0]};
                w_state_nxt = S_R_JUMP;
            end
            S_R_JUMP: begin
                hold_o      = 1'b1;
                jump_flag_o = 1'b1;
                jump_addr_o = mepc_i;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_trap_seq_ctrl.sv
// ============================================================================
// Module   : tb_trap_seq_ctrl
// Brief    : Directed scoreboard bench for trap_seq_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_trap_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_ecall_i, inst_ebreak_i, inst_mret_i;
    logic [31:0] inst_addr_i;
    logic        busy_i, irq_i;
    logic [31:0] mtvec_i, mepc_i, mstatus_i;
    logic        hold_o, csr_we_o, jump_flag_o;
    logic [31:0] csr_waddr_o, csr_wdata_o, jump_addr_o;

    int checks = 0;
    int errors = 0;
    logic [98:0] exp_q[$];

    always #5 clk = ~clk;

    trap_seq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_ecall_i (inst_ecall_i),
        .inst_ebreak_i(inst_ebreak_i),
        .inst_mret_i  (inst_mret_i),
        .inst_addr_i  (inst_addr_i),
        .busy_i       (busy_i),
        .irq_i        (irq_i),
        .mtvec_i      (mtvec_i),
        .mepc_i       (mepc_i),
        .mstatus_i    (mstatus_i),
        .hold_o       (hold_o),
        .csr_we_o     (csr_we_o),
        .csr_waddr_o  (csr_waddr_o),
        .csr_wdata_o  (csr_wdata_o),
        .jump_flag_o  (jump_flag_o),
        .jump_addr_o  (jump_addr_o)
    );

    // {hold, we, waddr, wdata, jump_flag, jump_addr}
    function automatic logic [98:0] ev(input logic h, input logic we,
                                       input logic [31:0] wa, input logic [31:0] wd,
                                       input logic jf, input logic [31:0] ja);
        return {h, we, wa, wd, jf, ja};
    endfunction

    // Push expectation for the current cycle, compare at negedge, step to next cycle.
    task automatic cyc(input string tag, input logic [98:0] e);
        logic [98:0] got;
        logic [98:0] want;
        exp_q.push_back(e);
        @(negedge clk);
        got  = {hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, jump_flag_o, jump_addr_o};
        want = exp_q.pop_front();
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        inst_ecall_i = 1'b0; inst_ebreak_i = 1'b0; inst_mret_i = 1'b0;
        inst_addr_i = 32'd0; busy_i = 1'b0; irq_i = 1'b0;
        mtvec_i = 32'h200; mepc_i = 32'd0; mstatus_i = 32'h8;

        cyc("reset", ev(0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        cyc("idle", ev(0, 0, 0, 0, 0, 0));

        // ecall trap entry
        inst_ecall_i = 1'b1; inst_addr_i = 32'h100;
        cyc("ecall_T", ev(1, 0, 0, 0, 0, 0));
        inst_ecall_i = 1'b0; inst_addr_i = 32'h104;
        cyc("ecall_mepc", ev(1, 1, 32'h341, 32'h100, 0, 0));
        cyc("ecall_mcause", ev(1, 1, 32'h342, 32'd11, 0, 0));
        cyc("ecall_mstatus", ev(1, 1, 32'h300, 32'h80, 0, 0));
        mstatus_i = 32'h80;
        cyc("ecall_jump", ev(1, 0, 0, 0, 1, 32'h200));
        cyc("ecall_done", ev(0, 0, 0, 0, 0, 0));

        // mret
        inst_mret_i = 1'b1; mepc_i = 32'h104; inst_addr_i = 32'h220;
        cyc("mret_T", ev(1, 0, 0, 0, 0, 0));
        inst_mret_i = 1'b0;
        cyc("mret_mstatus", ev(1, 1, 32'h300, 32'h88, 0, 0));
        mstatus_i = 32'h88;
        cyc("mret_jump", ev(1, 0, 0, 0, 1, 32'h104));
        cyc("mret_done", ev(0, 0, 0, 0, 0, 0));

        // ebreak with other mstatus bits passing through
        inst_ebreak_i = 1'b1; inst_addr_i = 32'h300; mstatus_i = 32'h0000_1808;
        mtvec_i = 32'h400;
        cyc("ebreak_T", ev(1, 0, 0, 0, 0, 0));
        inst_ebreak_i = 1'b0;
        cyc("ebreak_mepc", ev(1, 1, 32'h341, 32'h300, 0, 0));
        cyc("ebreak_mcause", ev(1, 1, 32'h342, 32'd3, 0, 0));
        cyc("ebreak_mstatus", ev(1, 1, 32'h300, 32'h0000_1880, 0, 0));
        cyc("ebreak_jump", ev(1, 0, 0, 0, 1, 32'h400));
        cyc("ebreak_done", ev(0, 0, 0, 0, 0, 0));

        // irq gated by MIE=0, then by busy
        irq_i = 1'b1; mstatus_i = 32'h0; mtvec_i = 32'h200;
        for (int i = 0; i < 10; i++) cyc("irq_masked", ev(0, 0, 0, 0, 0, 0));
        mstatus_i = 32'h8; busy_i = 1'b1; inst_addr_i = 32'h500;
        for (int i = 0; i < 3; i++) cyc("irq_busy", ev(0, 0, 0, 0, 0, 0));
        busy_i = 1'b0; inst_addr_i = 32'h504;
        cyc("irq_T", ev(1, 0, 0, 0, 0, 0));
        inst_addr_i = 32'h508;
        cyc("irq_mepc", ev(1, 1, 32'h341, 32'h504, 0, 0));
        cyc("irq_mcause", ev(1, 1, 32'h342, 32'h8000_0007, 0, 0));
        cyc("irq_mstatus", ev(1, 1, 32'h300, 32'h80, 0, 0));
        mstatus_i = 32'h80;
        cyc("irq_jump", ev(1, 0, 0, 0, 1, 32'h200));
        cyc("irq_no_retake0", ev(0, 0, 0, 0, 0, 0));
        cyc("irq_no_retake1", ev(0, 0, 0, 0, 0, 0));

        // ecall and enabled irq together: ecall wins
        mstatus_i = 32'h8; inst_ecall_i = 1'b1; inst_addr_i = 32'h600;
        cyc("prio_T", ev(1, 0, 0, 0, 0, 0));
        inst_ecall_i = 1'b0;
        cyc("prio_mepc", ev(1, 1, 32'h341, 32'h600, 0, 0));
        cyc("prio_mcause", ev(1, 1, 32'h342, 32'd11, 0, 0));
        cyc("prio_mstatus", ev(1, 1, 32'h300, 32'h80, 0, 0));
        mstatus_i = 32'h80;
        cyc("prio_jump", ev(1, 0, 0, 0, 1, 32'h200));
        cyc("prio_no_retake0", ev(0, 0, 0, 0, 0, 0));
        cyc("prio_no_retake1", ev(0, 0, 0, 0, 0, 0));
        irq_i = 1'b0;

        // async reset in W_MCAUSE
        mstatus_i = 32'h8; inst_ecall_i = 1'b1; inst_addr_i = 32'h700;
        cyc("rst_T", ev(1, 0, 0, 0, 0, 0));
        inst_ecall_i = 1'b0;
        cyc("rst_mepc", ev(1, 1, 32'h341, 32'h700, 0, 0));
        rst_n = 1'b0;
        cyc("rst_mid", ev(0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc("rst_after", ev(0, 0, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
